i2c_arb: RTL

I2C_ARB -- requirements
Module: i2c_arb

---
 rtl/i2c_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/i2c_arb.sv
// Two-port arbiter in front of a single I2C driver: one command slot per requester, round-robin grant.
// exec -> i2c_exec in 2 cycles; i2c_done -> doneN in 1 cycle; execN ignored while its slot is busy.
module i2c_arb #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exec0,
    input  logic        exec1,
    input  logic        rh_wl0,
    input  logic        rh_wl1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  data_w0,
    input  logic [7:0]  data_w1,
    output logic        busy0,
    output logic        busy1,
    output logic        done0,
    output logic        done1,
    output logic        ack0,
    output logic        ack1,
    output logic [7:0]  data_r0,
    output logic [7:0]  data_r1,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    input  logic [7:0]  i2c_data_r,
    output logic        to_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      r_state;
    logic        r_last;
    logic        r_gnt;
    logic [19:0] r_timer;
    logic        r_rh0, r_rh1;
    logic [15:0] r_addr0, r_addr1;
    logic [7:0]  r_dw0, r_dw1;

    logic w_gnt;
    logic w_to;

    // With both slots pending, the port not served last wins; otherwise the only pending one.
    assign w_gnt = (busy0 & busy1) ? ~r_last : ~busy0;
    assign w_to  = (r_timer == TIMEOUT_CYC - 20'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_gnt      <= 1'b0;
            r_timer    <= 20'd0;
            r_rh0      <= 1'b0;
            r_rh1      <= 1'b0;
            r_addr0    <= 16'h0000;
            r_addr1    <= 16'h0000;
            r_dw0      <= 8'h00;
            r_dw1      <= 8'h00;
            busy0      <= 1'b0;
            busy1      <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            data_r0    <= 8'h00;
            data_r1    <= 8'h00;
            i2c_exec   <= 1'b0;
            i2c_rh_wl  <= 1'b0;
            i2c_addr   <= 16'h0000;
            i2c_data_w <= 8'h00;
            to_err     <= 1'b0;
        end else begin
            done0    <= 1'b0;
            done1    <= 1'b0;
            i2c_exec <= 1'b0;

            if (exec0 && !busy0) begin
                busy0   <= 1'b1;
                r_rh0   <= rh_wl0;
                r_addr0 <= addr0;
                r_dw0   <= data_w0;
            end
            if (exec1 && !busy1) begin
                busy1   <= 1'b1;
                r_rh1   <= rh_wl1;
                r_addr1 <= addr1;
                r_dw1   <= data_w1;
            end

            case (r_state)
                IDLE: begin
                    if (busy0 || busy1) begin
                        // Command bus is loaded here so it is valid during the ISSUE strobe.
                        r_gnt      <= w_gnt;
                        i2c_exec   <= 1'b1;
                        i2c_rh_wl  <= w_gnt ? r_rh1   : r_rh0;
                        i2c_addr   <= w_gnt ? r_addr1 : r_addr0;
                        i2c_data_w <= w_gnt ? r_dw1   : r_dw0;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_timer <= 20'd0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (i2c_done) begin
                        if (r_gnt) begin
                            ack1    <= i2c_ack;
                            data_r1 <= i2c_data_r;
                            done1   <= 1'b1;
                        end else begin
                            ack0    <= i2c_ack;
                            data_r0 <= i2c_data_r;
                            done0   <= 1'b1;
                        end
                        r_state <= RESP;
                    end else if (w_to) begin
                        if (r_gnt) begin
                            ack1    <= 1'b1;
                            data_r1 <= 8'h00;
                            done1   <= 1'b1;
                        end else begin
                            ack0    <= 1'b1;
                            data_r0 <= 8'h00;
                            done0   <= 1'b1;
                        end
                        to_err  <= 1'b1;
                        r_state <= RESP;
                    end else if (r_timer != 20'hFFFFF) begin
                        r_timer <= r_timer + 20'd1;
                    end
                end
                RESP: begin
                    if (r_gnt) busy1 <= 1'b0;
                    else       busy0 <= 1'b0;
                    r_last  <= r_gnt;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
